clkout_seq_ctrl: RTL
====================

CLKOUT_SEQ_CTRL -- requirements
Module: clkout_seq_ctrl

Interface
REQ-001 SHALL have parameter IDLE_PATTERN, default 2'b00: value written to the PIO on park (end of sequence or abort).
REQ-002 SHALL have parameter CNT_W, default 16: width of the half-period and toggle-count fields.
REQ-003 SHALL have port clk, input, 1: single clock for all logic.
REQ-004 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have port cmd_valid, input, 1: requester presents a command.
REQ-006 SHALL have port cmd_ready, output, 1: controller accepts a command; high only in IDLE.
REQ-007 SHALL have port cmd_pattern_a, input, 2: phase-A output pattern.
REQ-008 SHALL have port cmd_pattern_b, input, 2: phase-B output pattern.
REQ-009 SHALL have port cmd_half_period, input, CNT_W: wait cycles between PIO writes; 0 is treated as 1.
REQ-010 SHALL have port cmd_toggles, input, CNT_W: number of pattern writes before park.
REQ-011 SHALL have port abort, input, 1: terminates the active sequence.
REQ-012 SHALL have port busy, output, 1: high whenever state is not IDLE.
REQ-013 SHALL have port done, output, 1: one-cycle pulse on return to IDLE.
REQ-014 SHALL have ports pio_address (output, 2), pio_chipselect (output, 1), pio_write_n (output, 1) and pio_writedata (output, 2): Avalon-MM master to the 2-bit clock-out PIO.
REQ-015 SHALL have port pio_readdata, input, 2: PIO readback data, combinational from the slave.
REQ-016 SHALL have port err, output, 1: sticky readback mismatch flag; present only with the macro.

Function
REQ-017 SHALL use states IDLE, WRITE, WAIT, PARK and DONE, plus READ when the macro is defined.
REQ-018 SHALL accept a command when cmd_valid and cmd_ready are both high, latching all cmd_* fields, setting phase=A, and moving to WRITE, or to PARK if cmd_toggles==0.
REQ-019 In WRITE, SHALL drive chipselect=1, write_n=0, address=0 and writedata equal to the current phase pattern for exactly one cycle, then decrement the remaining-toggle count.
REQ-020 In WAIT, SHALL count max(half_period,1) cycles, then flip the phase and go to WRITE if remaining>0, otherwise to PARK.
REQ-021 Write spacing SHALL be half_period+1 cycles, or half_period+2 cycles with readback enabled.
REQ-022 The first write SHALL occur on the cycle after acceptance.
REQ-023 In PARK, SHALL issue one write of IDLE_PATTERN, then go to DONE.
REQ-024 DONE SHALL assert done for one cycle, then return to IDLE.
REQ-025 Outside write and read cycles, pio_chipselect SHALL be 0, pio_write_n 1 and pio_address 0.
REQ-026 abort high in WRITE, WAIT or READ SHALL force PARK on the next cycle; in PARK or DONE it SHALL be ignored; in IDLE it SHALL be ignored, and abort with cmd_valid in IDLE SHALL still accept the command.
REQ-027 The counters SHALL never wrap: remaining saturates at 0, and the wait count reloads from the latched half_period.
REQ-028 cmd_* inputs SHALL be ignored while busy.

Reset
REQ-029 While reset is high, the controller SHALL be in IDLE with cmd_ready=1, busy=0, done=0, err=0, pio_chipselect=0, pio_write_n=1, pio_address=0, pio_writedata=0, and all counters at 0.
REQ-030 Reset asserted mid-sequence SHALL abandon the sequence without a park write.

Configuration
REQ-031 With macro CLKOUT_SEQ_READBACK_EN defined, every WRITE and PARK write SHALL be followed by one READ cycle (chipselect=1, write_n=1, address=0) that compares pio_readdata with the written value.
REQ-032 A readback mismatch SHALL set err, which SHALL clear only on the next command acceptance or on reset.
REQ-033 Without the macro, the READ state, the compare logic and the err port SHALL be absent.

Structure
REQ-034 Shared package clkout_seq_pkg SHALL hold the state enum, the PIO data register address constant (0) and the PIO width constant (2).
REQ-035 Sub-module clkout_seq_timer SHALL be the loadable down-counter with a zero flag, used for the wait count.

Verification
REQ-036 Scenario: A=01, B=10, half=3, toggles=4 -> writes 01,10,01,10 at cycles 1,5,9,13, then 00 at 17, done at 18.
REQ-037 Scenario: toggles=0 -> single IDLE_PATTERN write at cycle 1, done at cycle 2.
REQ-038 Scenario: half=0, toggles=2 -> writes 2 cycles apart, identical to half=1.
REQ-039 Scenario: abort during the second WAIT -> next cycle park write of 00, then done; no further pattern writes.
REQ-040 Scenario: reset pulse mid-WAIT -> all outputs at reset values immediately, no park write, cmd_ready=1.
REQ-041 Scenario (readback build): slave returns 11 after a write of 01 -> err=1 stays high until the next accepted command.

Source files
------------

// File: rtl/clkout_seq_pkg.sv
// Shared types and constants for the clock-out PIO sequencer.
// Optional readback build: define CLKOUT_SEQ_READBACK_EN to add the READ state.
package clkout_seq_pkg;

    localparam int unsigned PIO_W  = 2;
    localparam int unsigned ADDR_W = 2;

    // Address of the PIO data register.
    localparam logic [ADDR_W-1:0] PIO_DATA_ADDR = 2'd0;

    localparam logic PHASE_A = 1'b0;
    localparam logic PHASE_B = 1'b1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WRITE = 3'd1,
        WAIT  = 3'd2,
        PARK  = 3'd3,
        DONE  = 3'd4
`ifdef CLKOUT_SEQ_READBACK_EN
        ,
        READ  = 3'd5
`endif
    } state_e;

    // Pattern driven for the given phase.
    function automatic logic [PIO_W-1:0] phase_pattern(
        input logic             phase,
        input logic [PIO_W-1:0] pat_a,
        input logic [PIO_W-1:0] pat_b
    );
        return (phase == PHASE_B) ? pat_b : pat_a;
    endfunction

endpackage : clkout_seq_pkg

// File: rtl/clkout_seq_timer.sv
// Loadable down-counter with a registered zero flag; used for the inter-write wait.
module clkout_seq_timer #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             dec_i,
    output logic             zero_o
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic             zero_q;

    // Load has priority; decrement saturates at zero.
    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (dec_i && (count_q != '0)) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    // Counter and zero flag registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
            zero_q  <= 1'b1;
        end else begin
            count_q <= count_d;
            zero_q  <= (count_d == '0);
        end
    end

    assign zero_o = zero_q;

endmodule : clkout_seq_timer

// File: rtl/clkout_seq_ctrl.sv
// Clock-out sequencer: alternates two patterns on a 2-bit PIO via Avalon-MM writes,
// then parks the PIO at IDLE_PATTERN. Define CLKOUT_SEQ_READBACK_EN to read back
// every write and flag mismatches on err.
module clkout_seq_ctrl
    import clkout_seq_pkg::*;
#(
    parameter logic [PIO_W-1:0] IDLE_PATTERN = 2'b00,
    parameter int unsigned      CNT_W        = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [PIO_W-1:0]  cmd_pattern_a,
    input  logic [PIO_W-1:0]  cmd_pattern_b,
    input  logic [CNT_W-1:0]  cmd_half_period,
    input  logic [CNT_W-1:0]  cmd_toggles,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] pio_address,
    output logic              pio_chipselect,
    output logic              pio_write_n,
    output logic [PIO_W-1:0]  pio_writedata,
    input  logic [PIO_W-1:0]  pio_readdata
`ifdef CLKOUT_SEQ_READBACK_EN
    ,
    output logic              err
`endif
);

    state_e           state_q, state_d;
    logic             phase_q, phase_d;
    logic [PIO_W-1:0] pat_a_q, pat_a_d;
    logic [PIO_W-1:0] pat_b_q, pat_b_d;
    logic [CNT_W-1:0] half_q, half_d;
    logic [CNT_W-1:0] rem_q, rem_d;

    logic             cmd_ready_q, cmd_ready_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             pio_cs_q, pio_cs_d;
    logic             pio_we_n_q, pio_we_n_d;
    logic [PIO_W-1:0] pio_wdata_q, pio_wdata_d;

    logic             timer_load;
    logic             timer_dec;
    logic             timer_zero;
    logic [CNT_W-1:0] wait_len;

`ifdef CLKOUT_SEQ_READBACK_EN
    logic             err_q, err_d;
    logic             parking_q, parking_d;
    logic             is_read_d;
`else
    logic             unused_readdata;
    assign unused_readdata = ^pio_readdata;
`endif

    // A half period of 0 waits one cycle; the timer counts down to zero inclusive.
    assign wait_len = (half_q == '0) ? '0 : (half_q - CNT_W'(1));

    // Wait-count timer, reloaded on every pattern write.
    clkout_seq_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk        (clk),
        .reset      (reset),
        .load_i     (timer_load),
        .load_val_i (wait_len),
        .dec_i      (timer_dec),
        .zero_o     (timer_zero)
    );

    // Next-state, datapath and next-output logic.
    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        pat_a_d    = pat_a_q;
        pat_b_d    = pat_b_q;
        half_d     = half_q;
        rem_d      = rem_q;
        timer_load = 1'b0;
        timer_dec  = 1'b0;
`ifdef CLKOUT_SEQ_READBACK_EN
        err_d      = err_q;
        parking_d  = parking_q;
`endif

        case (state_q)
            IDLE: begin
                // abort is ignored here; a command is accepted regardless.
                if (cmd_valid) begin
                    pat_a_d = cmd_pattern_a;
                    pat_b_d = cmd_pattern_b;
                    half_d  = cmd_half_period;
                    rem_d   = cmd_toggles;
                    phase_d = PHASE_A;
                    state_d = (cmd_toggles == '0) ? PARK : WRITE;
`ifdef CLKOUT_SEQ_READBACK_EN
                    err_d   = 1'b0;
`endif
                end
            end

            WRITE: begin
                rem_d      = (rem_q == '0) ? '0 : (rem_q - CNT_W'(1));
                timer_load = 1'b1;
                if (abort) begin
                    state_d = PARK;
                end else begin
`ifdef CLKOUT_SEQ_READBACK_EN
                    state_d   = READ;
                    parking_d = 1'b0;
`else
                    state_d = WAIT;
`endif
                end
            end

            WAIT: begin
                if (abort) begin
                    state_d = PARK;
                end else if (timer_zero) begin
                    phase_d = ~phase_q;
                    state_d = (rem_q != '0) ? WRITE : PARK;
                end else begin
                    timer_dec = 1'b1;
                end
            end

            PARK: begin
`ifdef CLKOUT_SEQ_READBACK_EN
                state_d   = READ;
                parking_d = 1'b1;
`else
                state_d = DONE;
`endif
            end

`ifdef CLKOUT_SEQ_READBACK_EN
            READ: begin
                if (pio_readdata != pio_wdata_q) begin
                    err_d = 1'b1;
                end
                // The readback of the park write always completes; re-parking would loop.
                if (parking_q) begin
                    state_d = DONE;
                end else if (abort) begin
                    state_d = PARK;
                end else begin
                    state_d = WAIT;
                end
            end
`endif

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        // Outputs are registered, so they are decoded from the next state.
`ifdef CLKOUT_SEQ_READBACK_EN
        is_read_d = (state_d == READ);
`endif
        cmd_ready_d = (state_d == IDLE);
        busy_d      = (state_d != IDLE);
        done_d      = (state_d == DONE);
        pio_we_n_d  = !((state_d == WRITE) || (state_d == PARK));
`ifdef CLKOUT_SEQ_READBACK_EN
        pio_cs_d    = !pio_we_n_d || is_read_d;
`else
        pio_cs_d    = !pio_we_n_d;
`endif
        pio_wdata_d = pio_wdata_q;
        if (state_d == WRITE) begin
            pio_wdata_d = phase_pattern(phase_d, pat_a_d, pat_b_d);
        end else if (state_d == PARK) begin
            pio_wdata_d = IDLE_PATTERN;
        end
    end

    // State and command registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            phase_q   <= PHASE_A;
            pat_a_q   <= '0;
            pat_b_q   <= '0;
            half_q    <= '0;
            rem_q     <= '0;
`ifdef CLKOUT_SEQ_READBACK_EN
            err_q     <= 1'b0;
            parking_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            pat_a_q   <= pat_a_d;
            pat_b_q   <= pat_b_d;
            half_q    <= half_d;
            rem_q     <= rem_d;
`ifdef CLKOUT_SEQ_READBACK_EN
            err_q     <= err_d;
            parking_q <= parking_d;
`endif
        end
    end

    // Output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cmd_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pio_cs_q    <= 1'b0;
            pio_we_n_q  <= 1'b1;
            pio_wdata_q <= '0;
        end else begin
            cmd_ready_q <= cmd_ready_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pio_cs_q    <= pio_cs_d;
            pio_we_n_q  <= pio_we_n_d;
            pio_wdata_q <= pio_wdata_d;
        end
    end

    assign cmd_ready      = cmd_ready_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign pio_address    = PIO_DATA_ADDR;
    assign pio_chipselect = pio_cs_q;
    assign pio_write_n    = pio_we_n_q;
    assign pio_writedata  = pio_wdata_q;
`ifdef CLKOUT_SEQ_READBACK_EN
    assign err            = err_q;
`endif

endmodule : clkout_seq_ctrl
